// File: rtl/liteic_slave_node_read.sv
// liteic_slave_node_read: read-side slave node of the liteic crossbar.
// Round-robin AR arbitration among masters, locked on the winner until its R beat completes.
module liteic_slave_node_read #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int RDATA_WIDTH = 34
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [NUM_MASTERS-1:0] cbar_reqst_val_i,
    output logic [NUM_MASTERS-1:0] cbar_reqst_rdy_o,
    input  logic [ADDR_WIDTH-1:0]  cbar_reqst_data_i [NUM_MASTERS],
    output logic [NUM_MASTERS-1:0] cbar_resp_val_o,
    input  logic [NUM_MASTERS-1:0] cbar_resp_rdy_i,
    output logic [RDATA_WIDTH-1:0] cbar_resp_data_o,
    output logic                   slv_ar_valid_o,
    input  logic                   slv_ar_ready_i,
    output logic [ADDR_WIDTH-1:0]  slv_ar_addr_o,
    input  logic                   slv_r_valid_i,
    output logic                   slv_r_ready_o,
    input  logic [RDATA_WIDTH-1:0] slv_r_data_i
);
    localparam int PW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]          g_idx, pick_idx, cand, next_ptr;
    logic                   pick_found, g_val, g_rdy, in_ar, in_r;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (grant_q[i]) g_idx = PW'(i);
    end

    // First requester at or after rr_ptr_q, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = PW'((int'(rr_ptr_q) + i) % NUM_MASTERS);
            if (!pick_found && cbar_reqst_val_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign next_ptr = PW'((int'(g_idx) + 1) % NUM_MASTERS);
    assign g_val    = cbar_reqst_val_i[g_idx];
    assign g_rdy    = cbar_resp_rdy_i[g_idx];
    assign in_ar    = state_q == AR;
    assign in_r     = state_q == R;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE) begin
            if (pick_found) begin
                state_d           = AR;
                grant_d           = '0;
                grant_d[pick_idx] = 1'b1;
            end
        end else if (state_q == AR) begin
            if (g_val && slv_ar_ready_i) begin
                state_d = R;
            end else if (!g_val) begin
                state_d = IDLE;
                grant_d = '0;
            end
        end else if (slv_r_valid_i && g_rdy) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = next_ptr;
        end
    end

    assign slv_ar_valid_o   = in_ar & g_val;
    assign slv_ar_addr_o    = in_ar ? cbar_reqst_data_i[g_idx] : '0;
    assign cbar_reqst_rdy_o = in_ar ? grant_q & {NUM_MASTERS{slv_ar_ready_i}} : '0;
    assign cbar_resp_val_o  = in_r ? grant_q & {NUM_MASTERS{slv_r_valid_i}} : '0;
    assign slv_r_ready_o    = in_r & g_rdy;
    assign cbar_resp_data_o = slv_r_data_i;

    a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!rstn_i) $onehot0(grant_q));
    a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i) (state_q != IDLE) |-> $onehot(grant_q));
    a_rdy_onehot0: assert property (@(posedge clk_i) disable iff (!rstn_i) $onehot0(cbar_reqst_rdy_o));
    a_val_onehot0: assert property (@(posedge clk_i) disable iff (!rstn_i) $onehot0(cbar_resp_val_o));
endmodule
